// File: rtl/rf_wr_arb.sv
// rf_wr_arb: round-robin sharing of the 8x16 register-file write port; optional `RF_ARB_CLEAR_EN zero-fills r0..r7 after reset.
// Latency req->gnt/rf_write is 1 cycle; hold or no eligible request stalls grants and leaves requests pending.
module rf_wr_arb #(
   parameter int NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [3*NREQ-1:0]    req_regsel,
   input  logic [16*NREQ-1:0]   req_data,
   input  logic                 hold,
   output logic [NREQ-1:0]      gnt,
   output logic                 rf_write,
   output logic [2:0]           rf_writeregsel,
   output logic [15:0]          rf_writedata,
   output logic                 busy
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

`ifdef RF_ARB_CLEAR_EN
   localparam state_t RESET_ST = ST_CLEAR;
`else
   localparam state_t RESET_ST = ST_RUN;
`endif

   state_t            state_q;
   logic [2:0]        clr_cnt_q;
   logic [NREQ-1:0]   gnt_q;
   logic              rf_write_q;
   logic [2:0]        regsel_q;
   logic [15:0]       data_q;
   logic [PW-1:0]     ptr_q;

   logic [NREQ-1:0]   elig;
   logic              win_vld;
   logic [PW-1:0]     win_idx;
   int                scan_idx;
   logic [NREQ-1:0]   gnt_d;
   logic [PW-1:0]     ptr_d;
   logic [2:0]        regsel_d;
   logic [15:0]       data_d;

   // Last cycle's grantee only now sees its gnt, so its req is still the old payload.
   assign elig = req & ~gnt_q;

   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      scan_idx = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = int'(ptr_q) + k;
         if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
         if (!win_vld && elig[scan_idx[PW-1:0]]) begin
            win_vld = 1'b1;
            win_idx = scan_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      gnt_d          = '0;
      gnt_d[win_idx] = 1'b1;
      ptr_d          = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      regsel_d       = req_regsel[3*int'(win_idx) +: 3];
      data_d         = req_data[16*int'(win_idx) +: 16];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RESET_ST;
         clr_cnt_q  <= '0;
         gnt_q      <= '0;
         rf_write_q <= 1'b0;
         regsel_q   <= '0;
         data_q     <= '0;
         ptr_q      <= '0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               gnt_q <= '0;
               // Leave once the r7 write has been on the port for its cycle.
               if (rf_write_q && regsel_q == 3'd7) begin
                  rf_write_q <= 1'b0;
                  state_q    <= ST_RUN;
               end else begin
                  rf_write_q <= 1'b1;
                  regsel_q   <= clr_cnt_q;
                  data_q     <= '0;
                  clr_cnt_q  <= clr_cnt_q + 3'd1;
               end
            end
            default: begin
               if (win_vld && !hold) begin
                  gnt_q      <= gnt_d;
                  rf_write_q <= 1'b1;
                  regsel_q   <= regsel_d;
                  data_q     <= data_d;
                  ptr_q      <= ptr_d;
               end else begin
                  gnt_q      <= '0;
                  rf_write_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign gnt            = gnt_q;
   assign rf_write       = rf_write_q;
   assign rf_writeregsel = regsel_q;
   assign rf_writedata   = data_q;

`ifdef RF_ARB_CLEAR_EN
   assign busy = (state_q == ST_CLEAR);
`else
   assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arb.sv
// Bench for rf_wr_arb: directed steps plus random traffic against a cycle-level reference model.
module tb_rf_wr_arb;
   localparam int NREQ = 4;
`ifdef RF_ARB_CLEAR_EN
   localparam logic CLR = 1'b1;
`else
   localparam logic CLR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [3:0]    req = '0;
   logic [11:0]   req_regsel = '0;
   logic [63:0]   req_data = '0;
   logic          hold = 1'b0;
   logic [3:0]    gnt;
   logic          rf_write;
   logic [2:0]    rf_writeregsel;
   logic [15:0]   rf_writedata;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int            m_ptr;
   logic [3:0]    m_gnt;
   logic          m_wr;
   logic [2:0]    m_sel;
   logic [15:0]   m_data;
   logic          m_busy;
   bit            m_clear;
   int            m_clr_idx;
   logic [3:0]    prev_gnt;
   logic [15:0]   rf_img [8];

   rf_wr_arb #(.NREQ(NREQ)) dut (
      .clk(clk), .rst(rst), .req(req), .req_regsel(req_regsel), .req_data(req_data),
      .hold(hold), .gnt(gnt), .rf_write(rf_write), .rf_writeregsel(rf_writeregsel),
      .rf_writedata(rf_writedata), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_gnt = '0; m_wr = 1'b0; m_sel = '0; m_data = '0;
      m_clear = CLR; m_clr_idx = 0; m_busy = CLR; prev_gnt = '0;
   endtask

   // Predicts the outputs registered at the coming edge from the inputs now applied.
   task automatic model_edge();
      logic [3:0] el;
      int w;
      if (m_clear) begin
         m_gnt = '0;
         if (m_clr_idx < 8) begin
            m_wr = 1'b1; m_sel = 3'(m_clr_idx); m_data = '0; m_clr_idx++;
         end else begin
            m_wr = 1'b0; m_busy = 1'b0; m_clear = 1'b0;
         end
      end else begin
         el = req & ~m_gnt;
         w = -1;
         if (!hold)
            for (int k = 0; k < NREQ; k++)
               if (w < 0 && el[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         if (w >= 0) begin
            m_gnt = 4'(1 << w); m_wr = 1'b1;
            m_sel = req_regsel[3*w +: 3]; m_data = req_data[16*w +: 16];
            m_ptr = (w + 1) % NREQ;
         end else begin
            m_gnt = '0; m_wr = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk); #1;
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("rf_write", 32'(rf_write), 32'(m_wr));
      chk("regsel", 32'(rf_writeregsel), 32'(m_sel));
      chk("wdata", 32'(rf_writedata), 32'(m_data));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("gnt_twice", 32'(gnt & prev_gnt), 32'd0);
      prev_gnt = gnt;
      if (rf_write) rf_img[rf_writeregsel] = rf_writedata;
   endtask

   // Requesters that are idle or were just granted pick a new payload or drop.
   task automatic rand_reqs(input bit allow_hold);
      hold = allow_hold && ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NREQ; i++) begin
         if (m_gnt[i] || !req[i]) begin
            if ($urandom_range(0, 1) == 1) begin
               req[i] = 1'b1;
               req_regsel[3*i +: 3] = 3'($urandom);
               req_data[16*i +: 16] = 16'($urandom);
            end else begin
               req[i] = 1'b0;
            end
         end
      end
   endtask

   initial begin
      int wr_cnt;
      bit found;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_wr", 32'(rf_write), 32'd0);
      chk("rst_sel", 32'(rf_writeregsel), 32'd0);
      chk("rst_data", 32'(rf_writedata), 32'd0);
      chk("rst_busy", 32'(busy), 32'(CLR));
      rst = 1'b1;

`ifdef RF_ARB_CLEAR_EN
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("clr_wr", 32'(rf_write), 32'd1);
         chk("clr_sel", 32'(rf_writeregsel), 32'(i));
         chk("clr_busy", 32'(busy), 32'd1);
      end
      cyc();
      chk("clr_done_busy", 32'(busy), 32'd0);
      chk("clr_done_wr", 32'(rf_write), 32'd0);
`endif

      // all four requesting from pointer 0
      req = 4'hF;
      for (int i = 0; i < NREQ; i++) begin
         req_regsel[3*i +: 3] = 3'(i);
         req_data[16*i +: 16] = 16'hA000 + 16'(i);
      end
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("rr_order", 32'(gnt), 32'(1 << (i % 4)));
         chk("rr_wr", 32'(rf_write), 32'd1);
      end
      req = '0;
      repeat (2) cyc();

      // same destination register, pointer back at 0
      req = 4'b0011;
      req_regsel[2:0] = 3'd3; req_data[15:0]  = 16'h1111;
      req_regsel[5:3] = 3'd3; req_data[31:16] = 16'h2222;
      repeat (4) begin
         cyc();
         req = req & ~gnt;
      end
      chk("same_dst_r3", 32'(rf_img[3]), 32'h2222);

      // hold for three cycles with req[1] pending
      hold = 1'b1;
      req = 4'b0010; req_regsel[5:3] = 3'd6; req_data[31:16] = 16'h1234;
      repeat (3) begin
         cyc();
         chk("hold_gnt", 32'(gnt), 32'd0);
         chk("hold_wr", 32'(rf_write), 32'd0);
      end
      hold = 1'b0;
      cyc();
      chk("hold_release", 32'(gnt), 32'h2);
      req = '0;
      cyc();

      // lone requester: one write every other cycle
      req = 4'b0100; req_regsel[8:6] = 3'd5; req_data[47:32] = 16'hBEEF;
      wr_cnt = 0;
      repeat (6) begin
         cyc();
         wr_cnt += int'(rf_write);
      end
      chk("single_rate", 32'(wr_cnt), 32'd3);
      req = '0;
      cyc();
      chk("single_r5", 32'(rf_img[5]), 32'hBEEF);

      for (int c = 0; c < 400; c++) begin
         rand_reqs(1'b1);
         cyc();
      end

      // reset while gnt[3] is high
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         rand_reqs(1'b0);
         cyc();
         if (gnt[3]) found = 1'b1;
      end
      chk("wait_gnt3", 32'(found), 32'd1);
      rst = 1'b0;
      #1;
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_wr", 32'(rf_write), 32'd0);
      chk("midrst_sel", 32'(rf_writeregsel), 32'd0);
      chk("midrst_data", 32'(rf_writedata), 32'd0);
      chk("midrst_busy", 32'(busy), 32'(CLR));
      req = '0; hold = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
`ifdef RF_ARB_CLEAR_EN
      cyc();
      chk("clr_restart_wr", 32'(rf_write), 32'd1);
      chk("clr_restart_sel", 32'(rf_writeregsel), 32'd0);
      repeat (8) cyc();
`endif
      req = 4'b0010; req_regsel[5:3] = 3'd2; req_data[31:16] = 16'h5A5A;
      repeat (3) begin
         cyc();
         req = req & ~gnt;
      end
      chk("post_rst_r2", 32'(rf_img[2]), 32'h5A5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
